uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. Producer logic (LCD/debug message generators) writes bytes at full clock rate. The block stores them in a circular FIFO and feeds them one at a time into the transmitter's begin/busy/done handshake, so producers never poll the serial line.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- ADDR_WIDTH, 4, log2(DEPTH)

- i_clock  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_wrEn  in  1  write strobe, one byte per cycle
- i_wrData  in  8  byte to enqueue
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_count  out  ADDR_WIDTH+1  bytes stored, 0..DEPTH
- o_overflow  out  1  one-cycle pulse, write dropped because full
- o_idle  out  1  empty, FSM in S_IDLE and i_txBusy low
- o_txBegin  out  1  one-cycle launch pulse to transmitter
- o_txData  out  8  byte to transmitter, stable from launch until done
- i_txBusy  in  1  transmitter busy
- i_txDone  in  1  transmitter one-cycle completion pulse

## Operation
- Storage: DEPTH×8 array, wr_ptr/rd_ptr ADDR_WIDTH bits, natural wrap DEPTH-1→0; count is separate and registered.
- Write: accepted iff i_wrEn && !o_full, with full sampled at the start of the cycle. The byte goes to mem[wr_ptr] and wr_ptr increments. A write while full is discarded: no pointer or count change, o_overflow=1 next cycle.
- A pop and a write in the same cycle give a net count change of 0. A write rejected while full stays rejected even if a pop occurs in the same cycle.
- FSM states:
  - S_IDLE: if count≠0 and i_txBusy=0, then o_txData←mem[rd_ptr], o_txBegin←1, rd_ptr++, count−−, go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH: o_txBegin←0, go to S_WAIT_BUSY.
  - S_WAIT_BUSY: on i_txBusy=1 go to S_WAIT_DONE. If i_txDone=1 arrives first, go to S_IDLE.
  - S_WAIT_DONE: on i_txDone=1 go to S_IDLE.
- o_txData holds its value outside a launch; it changes only on a pop.
- The i_txBusy gate in S_IDLE prevents a launch while the transmitter is still finishing a frame, for example after a reset of this block alone.

## Timing
- Reset: all pointers and count 0, state S_IDLE, o_empty=1, o_full=0, o_count=0, o_overflow=0, o_txBegin=0, o_txData=8'h00, o_idle=1 if i_txBusy=0.
- Reset mid-frame: FIFO contents are lost and no further o_txBegin is issued until i_txBusy=0.
- All flags are registered and reflect state after the edge.
- Write at edge N into an empty FIFO: o_empty=0 and o_count=1 after N. o_txBegin is high for the cycle after edge N+1 and o_empty=1 again after N+1. Write-to-launch latency is 2 cycles.
- o_txBegin is exactly one cycle wide per byte and never asserted outside S_LAUNCH.
- Back-to-back bytes: i_txDone high in cycle D, S_IDLE in D+1, next o_txBegin in D+2 (provided i_txBusy has dropped).
- Bytes leave in write order. Dropped bytes are never transmitted.
- o_full asserts after the DEPTH-th accepted write. It deasserts the cycle after a pop.

## Test plan
- Reset with FIFO non-empty mid-frame and i_txBusy=1 → all outputs at reset values; no o_txBegin until i_txBusy falls.
- Single write 8'h41 into empty FIFO, transmitter model idle → o_txBegin pulse 2 cycles later with o_txData=8'h41 held until i_txDone; o_idle=1 after completion.
- Burst of 5 writes (8'h48,45,4C,4C,4F) with transmitter model (busy 1 cycle after begin, done after 100 cycles) → exactly 5 begin pulses in order, each 2 cycles after the previous done.
- Write 17 bytes with DEPTH=16 while the transmitter is stalled busy → o_full=1 after the 16th write; 17th dropped with a single o_overflow pulse; o_count=16.
- FIFO full and a pop coincide with i_wrEn → write rejected, o_count=15; then write accepted next cycle → o_count=16.
- Fill, drain fully, refill across the pointer wrap (20 bytes, interleaved) → output sequence matches input order with no duplicate or lost bytes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: buffers producer writes and launches
// them one at a time through the transmitter's begin/busy/done handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_wrEn,
  input  logic [7:0]            i_wrData,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_idle,
  output logic                  o_txBegin,
  output logic [7:0]            o_txData,
  input  logic                  i_txBusy,
  input  logic                  i_txDone
);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } state_e;

  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q;
  logic                  tx_begin_q;
  logic [7:0]            tx_data_q;

  logic full, empty, push, pop;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  // Full is judged on the registered count, so a same-cycle pop cannot rescue a write.
  assign push  = i_wrEn && !full;
  assign pop   = (state_q == StIdle) && !empty && !i_txBusy;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (ADDR_WIDTH + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StLaunch;
      end
      StLaunch: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // A done with no visible busy phase means the frame is already finished.
        if (i_txDone) begin
          state_d = StIdle;
        end else if (i_txBusy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (i_txDone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_wrData;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_begin_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= i_wrEn && full;
      tx_begin_q <= pop;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_WIDTH'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_txBegin  = tx_begin_q;
  assign o_txData   = tx_data_q;
  assign o_idle     = empty && (state_q == StIdle) && !i_txBusy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue-based model predicts every flag and launch
// while a small transmitter model answers the begin/busy/done handshake.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic          full, empty, overflow, idle, tx_begin;
  logic [AW:0]   count;
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_wrEn    (wr_en),
    .i_wrData  (wr_data),
    .o_full    (full),
    .o_empty   (empty),
    .o_count   (count),
    .o_overflow(overflow),
    .o_idle    (idle),
    .o_txBegin (tx_begin),
    .o_txData  (tx_data),
    .i_txBusy  (tx_busy),
    .i_txDone  (tx_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting in the FIFO, and whether the sequencer may launch.
  logic [7:0] q[$];
  bit         m_free = 1'b1;
  int         m_age  = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_begin, m_ovf;

  // Transmitter model.
  bit tx_stall = 1'b0;
  bit tx_fast  = 1'b0;
  bit tx_active = 1'b0;
  int tx_delay, tx_rem;
  int tx_len = 4;

  int cyc = 0;
  int last_done = -100;
  bit gap_chk = 1'b0;
  int begins = 0;

  task automatic step(input bit we, input logic [7:0] wd);
    bit acc, pop;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    if (tx_stall) begin
      tx_busy = 1'b1;
    end else if (tx_active) begin
      if (tx_delay > 0) begin
        tx_delay--;
      end else if (tx_rem > 0) begin
        tx_busy = 1'b1;
        tx_rem--;
      end else begin
        tx_done   = 1'b1;
        tx_active = 1'b0;
        last_done = cyc;
      end
    end
    wr_en   = we;
    wr_data = wd;

    acc     = we && (q.size() < DEPTH);
    pop     = m_free && (q.size() != 0) && !tx_busy;
    m_ovf   = we && !acc;
    m_begin = pop;
    if (pop) begin
      m_data = q.pop_front();
      m_free = 1'b0;
      m_age  = 0;
    end else if (!m_free) begin
      // A done is only seen once the launch cycle has passed.
      if (m_age >= 1 && tx_done) m_free = 1'b1;
      m_age++;
    end
    if (acc) q.push_back(wd);

    @(posedge clk);
    #1;
    cyc++;
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("tx_begin", 32'(tx_begin), 32'(m_begin));
    check("tx_data", 32'(tx_data), 32'(m_data));
    check("idle", 32'(idle), 32'(q.size() == 0 && m_free && !tx_busy));
    if (tx_begin) begin
      begins++;
      if (gap_chk && begins > 1) check("done_to_begin", 32'(cyc - last_done), 32'd2);
      tx_active = 1'b1;
      tx_delay  = 1;
      tx_rem    = tx_fast ? 0 : tx_len;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    q.delete();
    m_free = 1'b1;
    m_age  = 0;
    m_data = 8'h00;
    tx_active = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_begin", 32'(tx_begin), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_idle", 32'(idle), 32'(!tx_busy));
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !m_free || tx_active) && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check("drain_timeout", 32'(n >= 3000), 32'd0);
  endtask

  initial begin
    logic [7:0] hello [5];
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    #1;
    do_reset();

    // Single byte into an idle system.
    tx_len = 4;
    step(1'b1, 8'h41);
    drain();
    check("single_idle", 32'(idle), 32'd1);

    // Burst with slow transmitter: launches follow each done by two cycles.
    tx_len  = 100;
    begins  = 0;
    gap_chk = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, hello[i]);
    drain();
    check("burst_begins", 32'(begins), 32'd5);
    gap_chk = 1'b0;

    // Fill past full against a stalled transmitter.
    tx_stall = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h80 + i));
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    step(1'b0, 8'h00);
    check("ovf_single_pulse", 32'(overflow), 32'd0);

    // Pop and rejected write in the same cycle, then an accepted write.
    tx_stall = 1'b0;
    tx_len   = 3;
    step(1'b1, 8'hA5);
    check("pop_reject_count", 32'(count), 32'd15);
    check("pop_reject_ovf", 32'(overflow), 32'd1);
    step(1'b1, 8'hA6);
    check("refill_count", 32'(count), 32'd16);
    drain();

    // Interleaved writes across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      tx_len = $urandom_range(1, 4);
      step(1'b1, 8'(8'h60 + i));
      repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
    end
    drain();

    // Reset in the middle of a frame while the transmitter stays busy.
    tx_len = 50;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i));
    repeat (4) step(1'b0, 8'h00);
    tx_stall = 1'b1;
    do_reset();
    check("midframe_idle", 32'(idle), 32'd0);
    step(1'b1, 8'h5A);
    repeat (5) step(1'b0, 8'h00);
    check("held_launch_count", 32'(count), 32'd1);
    tx_stall = 1'b0;
    tx_len   = 3;
    drain();

    // Random traffic with varied transmitter behaviour.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) tx_stall = !tx_stall;
      tx_fast = ($urandom_range(0, 3) == 0);
      tx_len  = $urandom_range(1, 6);
      step(($urandom_range(0, 99) < 45), 8'($urandom));
    end
    tx_stall = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
